// File: rtl/sd_pkg.sv
// sd_pkg: types and constants shared by the SD data reader, writer and command controller.
package sd_pkg;
   typedef enum logic [2:0] {IDLE, WAIT_START, DATA, CRC, STOP, DONE} rd_state_t;
   typedef enum logic [1:0] {UNKNOWN, SDv1, SDv2, SDHCv2} card_type_t;
   localparam logic [15:0] CRC16_POLY = 16'h1021;
   localparam int SD_BLOCK_BYTES = 512;
endpackage

// File: rtl/sd_dat_reader_if.sv
// sd_dat_reader_if: host-side control and byte-stream signals of the SD block reader.
interface sd_dat_reader_if;
   logic rstart, rbusy, rdone, rtimeout, crc_ok, outen;
   logic [8:0] outaddr;
   logic [7:0] outbyte;
   modport master(output rstart, input rbusy, rdone, rtimeout, crc_ok, outen, outaddr, outbyte);
   modport slave(input rstart, output rbusy, rdone, rtimeout, crc_ok, outen, outaddr, outbyte);
endinterface

// File: rtl/sd_crc16_serial.sv
// sd_crc16_serial: bit-serial CRC16-CCITT (0x1021, init 0, no reflection), one bit per enable.
module sd_crc16_serial import sd_pkg::*; (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        en,
   input  logic        bit_in,
   output logic [15:0] crc
);
   logic fb;
   assign fb = bit_in ^ crc[15];
   always_ff @(posedge clk or posedge rst)
      if (rst) crc <= '0;
      else if (clr) crc <= '0;
      else if (en) crc <= {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
endmodule

// File: rtl/sd_dat_reader.sv
// sd_dat_reader: captures one SD data block from DAT0 (1-bit mode), streams bytes, checks CRC16 and end bit.
module sd_dat_reader import sd_pkg::*; #(
   parameter int DATTIMEOUT = 1000000,
   parameter int BLKBYTES   = SD_BLOCK_BYTES
) (
   input  logic clk,
   input  logic rst,
   input  logic sdclk,
   input  logic sddat0,
   sd_dat_reader_if.slave bus,
   output logic SD_D0_DIR
);
   localparam int TW = $clog2(DATTIMEOUT + 1);
   localparam logic [11:0] LAST_BIT = 12'(BLKBYTES * 8 - 1);
   rd_state_t state, state_n;
   logic sdclk_q, rise, crc_clr, crc_en, to_hit;
   logic [TW-1:0] tcnt;
   logic [11:0] bcnt;
   logic [6:0] sh;
   logic [15:0] rcrc, ccrc;
   assign rise = sdclk & ~sdclk_q;
   assign SD_D0_DIR = 1'b0;
   assign to_hit = tcnt == TW'(DATTIMEOUT - 1);
   assign crc_clr = state == IDLE && bus.rstart;
   assign crc_en = rise && state == DATA;
   sd_crc16_serial u_crc (.clk(clk), .rst(rst), .clr(crc_clr), .en(crc_en), .bit_in(sddat0), .crc(ccrc));
   always_comb begin
      state_n = state;
      case (state)
         IDLE:       state_n = bus.rstart ? WAIT_START : IDLE;
         WAIT_START: state_n = !rise ? WAIT_START : !sddat0 ? DATA : to_hit ? DONE : WAIT_START;
         DATA:       state_n = rise && bcnt == LAST_BIT ? CRC : DATA;
         CRC:        state_n = rise && bcnt == 12'd15 ? STOP : CRC;
         STOP:       state_n = rise ? DONE : STOP;
         default:    state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         sdclk_q <= 1'b0;
         tcnt <= '0;
         bcnt <= '0;
         sh <= '0;
         rcrc <= '0;
         bus.rbusy <= 1'b0;
         bus.rdone <= 1'b0;
         bus.rtimeout <= 1'b0;
         bus.crc_ok <= 1'b0;
         bus.outen <= 1'b0;
         bus.outaddr <= '0;
         bus.outbyte <= '0;
      end else begin
         sdclk_q <= sdclk;
         state <= state_n;
         bus.outen <= 1'b0;
         bus.rdone <= 1'b0;
         case (state)
            IDLE: if (bus.rstart) begin
               bus.rbusy <= 1'b1;
               bus.rtimeout <= 1'b0;
               bus.crc_ok <= 1'b0;
               tcnt <= '0;
               bcnt <= '0;
            end
            WAIT_START: if (rise) begin
               tcnt <= tcnt + TW'(1);
               bcnt <= '0;
               if (sddat0 && to_hit) bus.rtimeout <= 1'b1;
            end
            DATA: if (rise) begin
               sh <= {sh[5:0], sddat0};
               bcnt <= bcnt == LAST_BIT ? 12'd0 : bcnt + 12'd1;
               if (bcnt[2:0] == 3'd7) begin
                  bus.outen <= 1'b1;
                  bus.outbyte <= {sh, sddat0};
                  bus.outaddr <= bcnt[11:3];
               end
            end
            CRC: if (rise) begin
               rcrc <= {rcrc[14:0], sddat0};
               bcnt <= bcnt + 12'd1;
            end
            STOP: if (rise) bus.crc_ok <= (rcrc == ccrc) & sddat0;
            DONE: begin
               bus.rbusy <= 1'b0;
               bus.rdone <= 1'b1;
            end
            default: ;
         endcase
      end
endmodule

// File: doc/sd_dat_reader.md
Name: sd_dat_reader

Overview:
- Receive side of the SD single-block data path: after the command controller issues CMD17 (READ_SINGLE_BLOCK), this block captures one 512-byte block from DAT0 in 1-bit mode.
- Streams the bytes out with sector-relative byte addresses and checks the CRC16 and end bit.
- Sits beside the SD command controller, which owns sdclk. It is the read-direction counterpart of the sector writer and feeds the sector cache.

Parameters:
- DATTIMEOUT, 1000000: maximum sdclk rising edges to wait for the start bit before giving up.
- BLKBYTES, 512: bytes per block; must be a power of two, at most 512.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- sdclk  input  1  SD clock as generated by the command controller; sampled in the clk domain
- sddat0  input  1  DAT0 from the card, already synchronised to clk
- rstart  input  1  one-clk pulse: arm the receiver (issued when CMD17 is sent)
- rbusy  output  1  high from an accepted rstart until rdone
- rdone  output  1  one-clk pulse at end of operation
- rtimeout  output  1  valid with rdone: no start bit seen
- crc_ok  output  1  valid with rdone: CRC matched and end bit was 1
- outen  output  1  one-clk pulse: outbyte/outaddr valid
- outaddr  output  9  byte index within the block, 0..BLKBYTES-1
- outbyte  output  8  received byte, MSB first on the wire
- SD_D0_DIR  output  1  DECA level-shifter direction; held 0 (from card) at all times by this block

Behaviour:
- Edge detect: register sdclk into sdclk_q. rise = sdclk & ~sdclk_q. All sampling and state advance happens only on clk cycles where rise=1.
- Reset values: rbusy=0, rdone=0, rtimeout=0, crc_ok=0, outen=0, outaddr=0, outbyte=0, SD_D0_DIR=0. State=IDLE, counters=0, CRC register=0.
- States IDLE, WAIT_START, DATA, CRC, STOP, DONE.
- IDLE:
  - rstart=1 moves to WAIT_START next clk, sets rbusy=1, and clears the timeout counter, bit counter and CRC register.
  - If rstart coincides with rise, that edge is not sampled.
- WAIT_START: on each rise:
  - sddat0=0 (start bit) -> DATA; bit counter=0.
  - Otherwise the timeout counter increments. If it reaches DATTIMEOUT -> DONE with rtimeout=1, crc_ok=0.
- DATA:
  - On each rise, shift sddat0 into an 8-bit shift register (MSB first) and feed the bit to the CRC16 unit.
  - On the 8th bit of each byte, the following clk drives outen=1, outbyte=assembled byte, outaddr=byte index. Index 0 is the first byte after the start bit.
  - After bit BLKBYTES*8 -> CRC.
- CRC: shift 16 bits into the received-CRC register MSB first, without feeding the CRC unit. After 16 bits -> STOP.
- STOP: sample the end bit on the next rise. crc_ok = (received CRC == computed CRC) & (end bit == 1). Go to DONE.
- DONE: one clk; rdone=1, rbusy=0; return to IDLE. rtimeout and crc_ok hold their values until the next accepted rstart.
- CRC arithmetic: CRC16-CCITT, polynomial x^16+x^12+x^5+1 (0x1021), init 0x0000, no reflection, no final XOR. Computed over data bits only.
- rstart while rbusy=1 is ignored.
- outaddr wraps naturally at 9 bits and is never exceeded within a block.
- Reset asserted mid-operation returns everything to reset values immediately. No rdone is generated.
- sdclk stopped (no rise) freezes the FSM indefinitely. Timeout counts edges, not clk cycles.
- Latency: outen follows the sdclk rise that sampled the byte's last bit by exactly 1 clk. rdone follows the end-bit rise by 2 clk.

Decomposition:
- Shared package sd_pkg holds:
  - state enum rd_state_t
  - CRC16_POLY = 16'h1021
  - SD_BLOCK_BYTES = 512
  - card-type constants UNKNOWN/SDv1/SDv2/SDHCv2, shared with the writer and command controller
- One sub-module: sd_crc16_serial (clk, rst, clr, en, bit_in, crc[15:0]), a 1-bit-per-enable LFSR. The writer can reuse it.

Test Plan:
- Block of 512×0x00, CRC 0x0000, end bit 1 -> 512 outen pulses, outaddr 0..511, outbyte=0x00, rdone with crc_ok=1, rtimeout=0.
- Block of 512×0xFF, CRC 0x7FA1 -> all outbyte=0xFF, crc_ok=1. Same block with CRC 0x7FA0 -> crc_ok=0, still 512 outen pulses.
- Incrementing pattern (byte n = n mod 256), correct CRC, sdclk = clk/4 -> outbyte[k]=k mod 256 at outaddr k, each outen exactly 1 clk after the 8th-bit rise, crc_ok=1.
- Hold sddat0=1 after rstart, DATTIMEOUT=100 -> rdone exactly on the 2nd clk after the 100th rise; rtimeout=1, crc_ok=0, no outen.
- Correct data and CRC but end bit 0 -> crc_ok=0. A second rstart pulsed during DATA is ignored: rbusy stays 1 and outaddr continues.
- Assert rst after byte 200 -> all outputs 0 next clk with no rdone. A fresh rstart and valid block then completes with crc_ok=1.
